mioc_reset_seq: RTL and testbench
=================================

Name: mioc_reset_seq

Overview:
Parametrised reset sequencer for the MIOC. It generalises the fixed pushbutton/game-reset handling (PBRST_N, N_CVRST) into the following pipeline:
- NUM_SRC asynchronous active-low reset sources, each synchronised and debounced.
- A per-source routing mask onto NUM_OUT active-low reset outputs (e.g. RST_N, NETRST_N, CPRST_N).
- A stretch period, then staggered, ordered release of the outputs.

It sits between the board reset pins and the MIOC output reset drivers. Everything runs on B_PHI.

Parameters:
NUM_SRC, 2, number of reset source inputs (bit0 = PBRST_N, bit1 = N_CVRST by convention)
NUM_OUT, 3, number of reset outputs (bit0 = RST_N, bit1 = NETRST_N, bit2 = CPRST_N by convention)
DEBOUNCE_CYC, 4, consecutive stable synchronised samples needed to change a source's debounced state (>=1)
STRETCH_CYC, 16, cycles all outputs stay asserted after the last source deasserts (>=1)
STAGGER_CYC, 4, cycles between successive output releases (>=1)
SRC_OUT_MASK, {3'b101,3'b111}, NUM_SRC*NUM_OUT bits; row s (bits s*NUM_OUT +: NUM_OUT) selects the outputs reset by source s

Ports:
B_PHI  input  1  clock (Z80 clock)
PORRST_N  input  1  synchronous active-low reset (power-on)
SRC_N  input  NUM_SRC  asynchronous active-low reset requests
RSTOUT_N  output  NUM_OUT  active-low reset outputs, registered
BUSY  output  1  high whenever the FSM is not IDLE, registered

Behaviour:
- Interface: one clock, B_PHI. Reset PORRST_N is synchronous and active-low.
- PORRST_N low, sampled at a B_PHI rising edge:
  - RSTOUT_N = all 0; BUSY = 1.
  - State = STRETCH; active mask AM = all 1s.
  - Stretch/stagger counters = 0; release index = 0.
  - Sync flops = 1; debounced states = deasserted; debounce counters = 0.
  - Power-on therefore always produces a full stretch followed by a sequenced release.
- Per-source sync and debounce:
  - 2-flop synchroniser.
  - Debounced state D[s] flips after DEBOUNCE_CYC consecutive synchronised samples at the opposite level.
  - Any sample at the current level clears the counter.
- Latency: SRC_N[s] low and stable before edge 0 gives RSTOUT_N low (selected bits) at edge DEBOUNCE_CYC+2, i.e. visible after DEBOUNCE_CYC+3 edges counting edge 0.
- FSM states IDLE, HOLD, STRETCH, RELEASE:
  - IDLE: RSTOUT_N all 1, BUSY 0. If any D asserted, go to HOLD and set AM = OR of mask rows of asserted sources.
  - HOLD: RSTOUT_N[i] = 0 for every i in AM. Newly asserted sources OR their rows into AM each cycle; AM never shrinks in HOLD. When no D is asserted, go to STRETCH with counter = 0.
  - STRETCH: outputs held. Counter counts to STRETCH_CYC-1, then go to RELEASE with idx = 0 and cnt = 0. Any D asserted returns to HOLD (counter cleared, AM ORed).
  - RELEASE: cnt increments each cycle. At cnt == STAGGER_CYC-1, RSTOUT_N[idx] <= 1, idx++, cnt = 0. Every index consumes STAGGER_CYC cycles whether or not it is in AM. After idx NUM_OUT-1 is released, go to IDLE and clear AM.
  - Any D asserted during RELEASE returns to HOLD. On the next edge all AM outputs (including already-released ones) reassert, and idx and cnt clear.
- Outputs not in AM are never driven low during an episode.
- Simultaneous assertion of D and expiry of the stretch/stagger counter: the assertion wins.
- A source held low forever keeps the FSM in HOLD indefinitely.
- Counters are sized $clog2 of their limit +1. None of them wraps.

Optional Feature:
Macro MIOC_RSTCAUSE_EN.
- Defined: adds input CAUSE_CLR (1 bit) and output RST_CAUSE (NUM_SRC+1 bits).
  - Bit NUM_SRC is set by PORRST_N.
  - Bit s is set when source s enters or extends HOLD.
  - Bits are sticky across episodes.
  - A CAUSE_CLR high at an edge clears all bits, except set events at the same edge, which win.
  - PORRST_N sets the bits to {1, 0...0}.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- POR: PORRST_N low 3 cycles, then high. RSTOUT_N = 3'b000 for 16 cycles after release, then bit0 rises 4 cycles later, bit1 at 8, bit2 at 12. BUSY falls with bit2.
- SRC_N[1] (N_CVRST) pulsed low 20 cycles from IDLE:
  - RSTOUT_N = 3'b010 exactly 7 edges after the first low sample; bit1 is never driven low.
  - After deassert debounce plus 16 stretch cycles, bit0 releases at +4; bit2 releases at +12.
- Glitch rejection: SRC_N[0] low for 3 cycles (< DEBOUNCE_CYC). RSTOUT_N stays 3'b111 and BUSY stays 0.
- Re-assert during RELEASE: after bit0 has released, SRC_N[0] goes low. All bits return to 0; a fresh full stretch and stagger follows.
- Overlap: SRC_N[1] low, then SRC_N[0] low while in HOLD, then both high. AM = 3'b111; a single stretch follows.
- With MIOC_RSTCAUSE_EN: after the overlap case RST_CAUSE = 3'b111. CAUSE_CLR for 1 cycle gives 3'b000. A simultaneous CAUSE_CLR and new SRC_N[1] event gives 3'b010.

Source files
------------

// File: rtl/mioc_reset_seq.sv
// Reset sequencer: synchronise and debounce reset sources, route them onto reset outputs,
// stretch, then release outputs in order. Optional sticky cause register: MIOC_RSTCAUSE_EN.
module mioc_reset_seq #(
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned NUM_OUT      = 3,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned STRETCH_CYC  = 16,
  parameter int unsigned STAGGER_CYC  = 4,
  parameter logic [NUM_SRC*NUM_OUT-1:0] SRC_OUT_MASK = {3'b101, 3'b111}
) (
  input  logic               B_PHI,
  input  logic               PORRST_N,
  input  logic [NUM_SRC-1:0] SRC_N,
`ifdef MIOC_RSTCAUSE_EN
  input  logic               CAUSE_CLR,
  output logic [NUM_SRC:0]   RST_CAUSE,
`endif
  output logic [NUM_OUT-1:0] RSTOUT_N,
  output logic               BUSY
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC) + 1;
  localparam int unsigned ST_W = $clog2(STRETCH_CYC) + 1;
  localparam int unsigned SG_W = $clog2(STAGGER_CYC) + 1;
  localparam int unsigned IX_W = $clog2(NUM_OUT) + 1;

  typedef enum logic [1:0] {IDLE, HOLD, STRETCH, RELEASE} state_e;

  logic [NUM_SRC-1:0] sync1_q, sync2_q, act_q;
  logic [DB_W-1:0]    db_cnt_q [NUM_SRC];
  state_e             state_q;
  logic [NUM_OUT-1:0] am_q, rstout_q;
  logic               busy_q;
  logic [ST_W-1:0]    st_cnt_q;
  logic [SG_W-1:0]    sg_cnt_q;
  logic [IX_W-1:0]    idx_q;
  logic [NUM_OUT-1:0] row_or_c, am_hold_c, rel_c;
  logic               any_c;

  // Routing of asserted sources and one-hot select of the output being released.
  always_comb begin
    row_or_c = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (act_q[s]) row_or_c = row_or_c | SRC_OUT_MASK[s*NUM_OUT +: NUM_OUT];
    end
    any_c     = |act_q;
    am_hold_c = am_q | row_or_c;
    rel_c     = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (idx_q == IX_W'(i)) rel_c[i] = 1'b1;
    end
  end

  // Two-flop synchroniser plus per-source debounce; act_q is 1 while a source is asserted.
  always_ff @(posedge B_PHI) begin
    if (!PORRST_N) begin
      sync1_q <= '1;
      sync2_q <= '1;
      act_q   <= '0;
      for (int s = 0; s < NUM_SRC; s++) db_cnt_q[s] <= '0;
    end else begin
      sync1_q <= SRC_N;
      sync2_q <= sync1_q;
      for (int s = 0; s < NUM_SRC; s++) begin
        if ((~sync2_q[s]) != act_q[s]) begin
          if (db_cnt_q[s] == DB_W'(DEBOUNCE_CYC - 1)) begin
            act_q[s]    <= ~act_q[s];
            db_cnt_q[s] <= '0;
          end else begin
            db_cnt_q[s] <= db_cnt_q[s] + DB_W'(1);
          end
        end else begin
          db_cnt_q[s] <= '0;
        end
      end
    end
  end

  // Sequencer FSM; outputs are computed for the state being entered so they stay registered.
  always_ff @(posedge B_PHI) begin
    if (!PORRST_N) begin
      state_q  <= STRETCH;
      am_q     <= '1;
      rstout_q <= '0;
      busy_q   <= 1'b1;
      st_cnt_q <= '0;
      sg_cnt_q <= '0;
      idx_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rstout_q <= '1;
          busy_q   <= 1'b0;
          if (any_c) begin
            state_q  <= HOLD;
            am_q     <= am_hold_c;
            rstout_q <= ~am_hold_c;
            busy_q   <= 1'b1;
          end
        end
        HOLD: begin
          am_q     <= am_hold_c;
          rstout_q <= ~am_hold_c;
          if (!any_c) begin
            state_q  <= STRETCH;
            st_cnt_q <= '0;
          end
        end
        STRETCH: begin
          if (any_c) begin
            state_q  <= HOLD;
            am_q     <= am_hold_c;
            rstout_q <= ~am_hold_c;
            st_cnt_q <= '0;
          end else if (st_cnt_q == ST_W'(STRETCH_CYC - 1)) begin
            state_q  <= RELEASE;
            idx_q    <= '0;
            sg_cnt_q <= '0;
          end else begin
            st_cnt_q <= st_cnt_q + ST_W'(1);
          end
        end
        RELEASE: begin
          // A fresh assertion beats a counter expiry and re-asserts already released outputs.
          if (any_c) begin
            state_q  <= HOLD;
            am_q     <= am_hold_c;
            rstout_q <= ~am_hold_c;
            idx_q    <= '0;
            sg_cnt_q <= '0;
          end else if (sg_cnt_q == SG_W'(STAGGER_CYC - 1)) begin
            rstout_q <= rstout_q | rel_c;
            sg_cnt_q <= '0;
            if (idx_q == IX_W'(NUM_OUT - 1)) begin
              state_q <= IDLE;
              am_q    <= '0;
              busy_q  <= 1'b0;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + IX_W'(1);
            end
          end else begin
            sg_cnt_q <= sg_cnt_q + SG_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MIOC_RSTCAUSE_EN
  logic [NUM_SRC:0] cause_q;

  // Sticky cause bits; a source asserted this cycle forces HOLD, so it sets its bit even during a clear.
  always_ff @(posedge B_PHI) begin
    if (!PORRST_N) begin
      cause_q <= {1'b1, {NUM_SRC{1'b0}}};
    end else begin
      cause_q <= (CAUSE_CLR ? '0 : cause_q) | {1'b0, act_q};
    end
  end

  assign RST_CAUSE = cause_q;
`endif

  assign RSTOUT_N = rstout_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_mioc_reset_seq.sv
// Directed bench for mioc_reset_seq: scoreboard of expected RSTOUT_N/BUSY per step,
// plus RST_CAUSE checks when MIOC_RSTCAUSE_EN is defined.
module tb_mioc_reset_seq;

  logic       B_PHI = 1'b0;
  logic       PORRST_N;
  logic [1:0] SRC_N;
  logic [2:0] RSTOUT_N;
  logic       BUSY;
`ifdef MIOC_RSTCAUSE_EN
  logic       CAUSE_CLR;
  logic [2:0] RST_CAUSE;
`endif

  int checks = 0;
  int errors = 0;
  int b1_low = 0;
  logic watch_b1 = 1'b0;

  typedef struct packed {
    logic [2:0] rst;
    logic       busy;
  } exp_t;
  exp_t sb[$];

  mioc_reset_seq dut (
    .B_PHI    (B_PHI),
    .PORRST_N (PORRST_N),
    .SRC_N    (SRC_N),
`ifdef MIOC_RSTCAUSE_EN
    .CAUSE_CLR(CAUSE_CLR),
    .RST_CAUSE(RST_CAUSE),
`endif
    .RSTOUT_N (RSTOUT_N),
    .BUSY     (BUSY)
  );

  always #5 B_PHI = ~B_PHI;

  // Source 1 is not routed to output bit1, so bit1 must stay high while it is the only source.
  always @(negedge B_PHI) begin
    if (watch_b1 && RSTOUT_N[1] !== 1'b1) b1_low <= b1_low + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge B_PHI);
      #1;
    end
  endtask

  // Queue the expectation, advance n edges, then pop and compare.
  task automatic expect_after(input int n, input logic [2:0] rst, input logic busy,
                              input string tag);
    exp_t e;
    e.rst  = rst;
    e.busy = busy;
    sb.push_back(e);
    tick(n);
    e = sb.pop_front();
    checks++;
    assert (RSTOUT_N === e.rst) else begin
      errors++;
      $error("FAIL %s: RSTOUT_N observed %b expected %b", tag, RSTOUT_N, e.rst);
    end
    checks++;
    assert (BUSY === e.busy) else begin
      errors++;
      $error("FAIL %s: BUSY observed %b expected %b", tag, BUSY, e.busy);
    end
  endtask

`ifdef MIOC_RSTCAUSE_EN
  task automatic chk_cause(input logic [2:0] exp_c, input string tag);
    checks++;
    assert (RST_CAUSE === exp_c) else begin
      errors++;
      $error("FAIL %s: RST_CAUSE observed %b expected %b", tag, RST_CAUSE, exp_c);
    end
  endtask
`endif

  initial begin
    PORRST_N = 1'b0;
    SRC_N    = 2'b11;
`ifdef MIOC_RSTCAUSE_EN
    CAUSE_CLR = 1'b0;
`endif

    // Power-on: three low edges, then full stretch and staggered release.
    expect_after(1, 3'b000, 1'b1, "por_reset");
`ifdef MIOC_RSTCAUSE_EN
    chk_cause(3'b100, "por_cause");
`endif
    tick(2);
    PORRST_N = 1'b1;
    expect_after(15, 3'b000, 1'b1, "por_stretch15");
    expect_after(1,  3'b000, 1'b1, "por_stretch16");
    expect_after(3,  3'b000, 1'b1, "por_pre_b0");
    expect_after(1,  3'b001, 1'b1, "por_b0");
    expect_after(3,  3'b001, 1'b1, "por_pre_b1");
    expect_after(1,  3'b011, 1'b1, "por_b1");
    expect_after(3,  3'b011, 1'b1, "por_pre_b2");
    expect_after(1,  3'b111, 1'b0, "por_idle");

    // N_CVRST pulse of 20 cycles: bits 0 and 2 only.
    watch_b1 = 1'b1;
    SRC_N = 2'b01;
    expect_after(6,  3'b111, 1'b0, "cv_pre_assert");
    expect_after(1,  3'b010, 1'b1, "cv_assert");
    expect_after(13, 3'b010, 1'b1, "cv_hold");
    SRC_N = 2'b11;
    expect_after(26, 3'b010, 1'b1, "cv_pre_b0");
    expect_after(1,  3'b011, 1'b1, "cv_b0");
    expect_after(7,  3'b011, 1'b1, "cv_pre_b2");
    expect_after(1,  3'b111, 1'b0, "cv_idle");
    watch_b1 = 1'b0;
    checks++;
    assert (b1_low == 0) else begin
      errors++;
      $error("FAIL cv_bit1_low: low cycles observed %0d expected 0", b1_low);
    end

    // Glitch shorter than the debounce window.
    SRC_N = 2'b10;
    expect_after(3,  3'b111, 1'b0, "glitch_low");
    SRC_N = 2'b11;
    expect_after(10, 3'b111, 1'b0, "glitch_after");

    // Re-assert during RELEASE.
    SRC_N = 2'b10;
    expect_after(7,  3'b000, 1'b1, "re_assert");
    tick(3);
    SRC_N = 2'b11;
    expect_after(27, 3'b001, 1'b1, "re_b0");
    SRC_N = 2'b10;
    expect_after(4,  3'b011, 1'b1, "re_b1");
    expect_after(2,  3'b011, 1'b1, "re_pre_reassert");
    expect_after(1,  3'b000, 1'b1, "re_reassert");
    tick(6);
    SRC_N = 2'b11;
    expect_after(26, 3'b000, 1'b1, "re_pre_b0");
    expect_after(1,  3'b001, 1'b1, "re2_b0");
    expect_after(4,  3'b011, 1'b1, "re2_b1");
    expect_after(4,  3'b111, 1'b0, "re2_idle");

    // Overlap: source 1 then source 0 while in HOLD; one stretch for both.
    SRC_N = 2'b01;
    expect_after(7,  3'b010, 1'b1, "ov_src1");
    tick(3);
    SRC_N = 2'b00;
    expect_after(6,  3'b010, 1'b1, "ov_pre_src0");
    expect_after(1,  3'b000, 1'b1, "ov_src0");
    tick(3);
    SRC_N = 2'b11;
    expect_after(26, 3'b000, 1'b1, "ov_pre_b0");
    expect_after(1,  3'b001, 1'b1, "ov_b0");
    expect_after(4,  3'b011, 1'b1, "ov_b1");
    expect_after(4,  3'b111, 1'b0, "ov_idle");

`ifdef MIOC_RSTCAUSE_EN
    chk_cause(3'b111, "cause_overlap");
    CAUSE_CLR = 1'b1;
    tick(1);
    CAUSE_CLR = 1'b0;
    chk_cause(3'b000, "cause_clear");
    SRC_N = 2'b01;
    tick(6);
    chk_cause(3'b000, "cause_pre_set");
    CAUSE_CLR = 1'b1;
    expect_after(1, 3'b010, 1'b1, "cause_src1");
    CAUSE_CLR = 1'b0;
    chk_cause(3'b010, "cause_set_wins");
    tick(3);
    SRC_N = 2'b11;
    expect_after(35, 3'b111, 1'b0, "cause_idle");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
